// File: rtl/iics.sv
// -----------------------------------------------------------------------------
// iics - I2C slave receiver (write-only register target)
//
// Watches SCL/SDA, decodes START/STOP, a 7-bit device address, a register
// pointer byte and any number of data bytes. Each accepted byte is ACKed by
// pulling SDA low for the ninth clock, and each data byte is delivered as a
// one-cycle register write. Read requests (R/W=1) and foreign addresses are
// not acknowledged; the block then ignores the bus until the next START/STOP.
//
// Ports:
//   clk      in   system clock, at least 8x the SCL rate
//   rst      in   synchronous active-high reset
//   scl_in   in   SCL pin level (asynchronous)
//   sda_in   in   SDA pin level (asynchronous)
//   sda_oe   out  1 = drive SDA low (ACK), 0 = release
//   wr_en    out  one-cycle register write strobe
//   wr_addr  out  register address of the write
//   wr_data  out  register data of the write
//   busy     out  1 between an address-matched START and the following STOP
// -----------------------------------------------------------------------------
module iics #(
    parameter logic [7:0] CHIP_ADDR = 8'hD0,
    parameter int         FILT      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK_A  = 3'd2,
        REG    = 3'd3,
        ACK_R  = 3'd4,
        DATA   = 3'd5,
        ACK_D  = 3'd6,
        IGNORE = 3'd7
    } state_t;

    logic [FILT-1:0] scl_sync_r;
    logic [FILT-1:0] sda_sync_r;
    logic            scl_prev_r;
    logic            sda_prev_r;
    logic            scl_s;
    logic            sda_s;
    logic            scl_rise_s;
    logic            scl_fall_s;
    logic            start_s;
    logic            stop_s;
    logic [7:0]      byte_s;

    state_t     state_r,   state_nxt_s;
    logic [2:0] cnt_r,     cnt_nxt_s;
    logic [7:0] shift_r,   shift_nxt_s;
    logic [7:0] ptr_r,     ptr_nxt_s;
    logic       sda_oe_r,  sda_oe_nxt_s;
    logic       busy_r,    busy_nxt_s;
    logic       wr_en_r,   wr_en_nxt_s;
    logic [7:0] wr_addr_r, wr_addr_nxt_s;
    logic [7:0] wr_data_r, wr_data_nxt_s;

    assign scl_s      = scl_sync_r[FILT-1];
    assign sda_s      = sda_sync_r[FILT-1];
    assign scl_rise_s = scl_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_s & scl_prev_r;
    // Bus conditions only exist while SCL is high; data never changes then.
    assign start_s    = scl_s & sda_prev_r & ~sda_s;
    assign stop_s     = scl_s & ~sda_prev_r & sda_s;
    // Byte as it will look once the bit being sampled now is shifted in.
    assign byte_s     = {shift_r[6:0], sda_s};

    assign sda_oe  = sda_oe_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign busy    = busy_r;

    // Pin synchronisers and previous-sample flops for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_r <= {FILT{1'b1}};
            sda_sync_r <= {FILT{1'b1}};
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[FILT-2:0], scl_in};
            sda_sync_r <= {sda_sync_r[FILT-2:0], sda_in};
            scl_prev_r <= scl_s;
            sda_prev_r <= sda_s;
        end
    end

    // Protocol state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 3'd0;
            shift_r   <= 8'd0;
            ptr_r     <= 8'd0;
            sda_oe_r  <= 1'b0;
            busy_r    <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= 8'd0;
            wr_data_r <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            ptr_r     <= ptr_nxt_s;
            sda_oe_r  <= sda_oe_nxt_s;
            busy_r    <= busy_nxt_s;
            wr_en_r   <= wr_en_nxt_s;
            wr_addr_r <= wr_addr_nxt_s;
            wr_data_r <= wr_data_nxt_s;
        end
    end

    // Next-state logic: START/STOP first, then bit sampling and ACK slots.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        shift_nxt_s   = shift_r;
        ptr_nxt_s     = ptr_r;
        sda_oe_nxt_s  = sda_oe_r;
        busy_nxt_s    = busy_r;
        wr_en_nxt_s   = 1'b0;
        wr_addr_nxt_s = wr_addr_r;
        wr_data_nxt_s = wr_data_r;

        if (stop_s) begin
            state_nxt_s  = IDLE;
            cnt_nxt_s    = 3'd0;
            sda_oe_nxt_s = 1'b0;
            busy_nxt_s   = 1'b0;
        end else if (start_s) begin
            // Repeated START keeps busy and the pointer until the address resolves.
            state_nxt_s  = ADDR;
            cnt_nxt_s    = 3'd0;
            sda_oe_nxt_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    sda_oe_nxt_s = 1'b0;
                end
                ADDR, REG, DATA: begin
                    if (scl_rise_s) begin
                        shift_nxt_s = byte_s;
                        cnt_nxt_s   = cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            if (state_r == ADDR) begin
                                if ((byte_s[7:1] == CHIP_ADDR[7:1]) && (byte_s[0] == 1'b0)) begin
                                    state_nxt_s = ACK_A;
                                end else begin
                                    state_nxt_s = IGNORE;
                                    busy_nxt_s  = 1'b0;
                                end
                            end else if (state_r == REG) begin
                                ptr_nxt_s   = byte_s;
                                state_nxt_s = ACK_R;
                            end else begin
                                wr_en_nxt_s   = 1'b1;
                                wr_addr_nxt_s = ptr_r;
                                wr_data_nxt_s = byte_s;
                                ptr_nxt_s     = ptr_r + 8'd1;
                                state_nxt_s   = ACK_D;
                            end
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end else begin
                        shift_nxt_s = shift_r;
                    end
                end
                ACK_A, ACK_R, ACK_D: begin
                    // sda_oe doubles as the phase bit: first fall drives, second releases.
                    if (scl_fall_s) begin
                        if (!sda_oe_r) begin
                            sda_oe_nxt_s = 1'b1;
                            busy_nxt_s   = 1'b1;
                        end else begin
                            sda_oe_nxt_s = 1'b0;
                            cnt_nxt_s    = 3'd0;
                            if (state_r == ACK_A) begin
                                state_nxt_s = REG;
                            end else begin
                                state_nxt_s = DATA;
                            end
                        end
                    end else begin
                        sda_oe_nxt_s = sda_oe_r;
                    end
                end
                IGNORE: begin
                    sda_oe_nxt_s = 1'b0;
                end
                default: begin
                    state_nxt_s  = IDLE;
                    sda_oe_nxt_s = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iics.sv
// -----------------------------------------------------------------------------
// tb_iics - self-checking bench for the iics I2C slave receiver.
// A bench-side I2C master bit-bangs directed transfers on an open-drain bus.
// Expected register writes are queued as stimulus is issued; a monitor pops
// and compares whenever wr_en is seen. ACK slots and busy are checked inline.
// -----------------------------------------------------------------------------
module tb_iics;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    // Open-drain bus: either side can pull SDA low.
    assign sda_bus = sda_m & ~sda_oe;

    iics #(.CHIP_ADDR(8'hD0), .FILT(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_in  (scl_m),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period starting and ending with SCL low; returns SDA seen while high.
    task automatic scl_cycle(input logic b, output logic seen);
        wait_clk(4);
        sda_m = b;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(4);
        seen = sda_bus;
        wait_clk(4);
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic seen;
        for (int i = 7; i >= 0; i--) begin
            scl_cycle(b[i], seen);
        end
        scl_cycle(1'b1, seen);
        check(name, 16'(!seen), 16'(exp_ack));
    endtask

    task automatic start_cond();
        sda_m = 1'b0;
        wait_clk(4);
        scl_m = 1'b0;
    endtask

    task automatic rstart_cond();
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(4);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({wr_addr, wr_data} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                             wr_addr, wr_data, mon_exp[15:8], mon_exp[7:0]);
                end
            end
        end
    end

    // Hard stop if the run wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        logic seen;

        rst   = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(3);
        check("rst_sda_oe",  16'(sda_oe),  16'd0);
        check("rst_wr_en",   16'(wr_en),   16'd0);
        check("rst_wr_addr", 16'(wr_addr), 16'd0);
        check("rst_wr_data", 16'(wr_data), 16'd0);
        check("rst_busy",    16'(busy),    16'd0);
        rst = 1'b0;
        wait_clk(5);

        // 1: D0, 00, 95 -> one write 00/95, busy from first ACK to STOP
        exp_q.push_back({8'h00, 8'h95});
        start_cond();
        check("t1_busy_pre", 16'(busy), 16'd0);
        send_byte(8'hD0, 1'b1, "t1_ack_addr");
        check("t1_busy_ack", 16'(busy), 16'd1);
        send_byte(8'h00, 1'b1, "t1_ack_reg");
        send_byte(8'h95, 1'b1, "t1_ack_data");
        check("t1_busy_data", 16'(busy), 16'd1);
        stop_cond();
        wait_clk(2);
        check("t1_busy_stop", 16'(busy), 16'd0);
        check("t1_pending", 16'(exp_q.size()), 16'd0);

        // 2: foreign address A0 -> no ACK, no write, busy low
        start_cond();
        send_byte(8'hA0, 1'b0, "t2_nack_addr");
        send_byte(8'h00, 1'b0, "t2_nack_b1");
        send_byte(8'h55, 1'b0, "t2_nack_b2");
        check("t2_busy", 16'(busy), 16'd0);
        stop_cond();
        wait_clk(2);

        // 3: read address D1 -> not acknowledged, ignored until STOP
        start_cond();
        send_byte(8'hD1, 1'b0, "t3_nack_read");
        check("t3_busy", 16'(busy), 16'd0);
        send_byte(8'h5A, 1'b0, "t3_nack_b1");
        stop_cond();
        wait_clk(2);

        // 4: burst from FE with pointer wrap
        exp_q.push_back({8'hFE, 8'h11});
        exp_q.push_back({8'hFF, 8'h22});
        exp_q.push_back({8'h00, 8'h33});
        start_cond();
        send_byte(8'hD0, 1'b1, "t4_ack_addr");
        send_byte(8'hFE, 1'b1, "t4_ack_reg");
        send_byte(8'h11, 1'b1, "t4_ack_d0");
        send_byte(8'h22, 1'b1, "t4_ack_d1");
        send_byte(8'h33, 1'b1, "t4_ack_d2");
        stop_cond();
        wait_clk(2);
        check("t4_pending", 16'(exp_q.size()), 16'd0);

        // 5: STOP after 4 data bits discards the byte; next transfer writes 20/AA
        start_cond();
        send_byte(8'hD0, 1'b1, "t5_ack_addr");
        send_byte(8'h10, 1'b1, "t5_ack_reg");
        scl_cycle(1'b1, seen);
        scl_cycle(1'b0, seen);
        scl_cycle(1'b1, seen);
        scl_cycle(1'b0, seen);
        stop_cond();
        wait_clk(2);
        check("t5_busy_stop", 16'(busy), 16'd0);
        exp_q.push_back({8'h20, 8'hAA});
        start_cond();
        send_byte(8'hD0, 1'b1, "t5_ack_addr2");
        send_byte(8'h20, 1'b1, "t5_ack_reg2");
        send_byte(8'hAA, 1'b1, "t5_ack_data2");
        stop_cond();
        wait_clk(2);
        check("t5_pending", 16'(exp_q.size()), 16'd0);

        // 6: repeated START keeps busy until a mismatching address drops it
        start_cond();
        send_byte(8'hD0, 1'b1, "t6_ack_addr");
        send_byte(8'h40, 1'b1, "t6_ack_reg");
        rstart_cond();
        check("t6_busy_sr", 16'(busy), 16'd1);
        send_byte(8'hA0, 1'b0, "t6_nack_addr");
        check("t6_busy_mismatch", 16'(busy), 16'd0);
        stop_cond();
        wait_clk(2);

        // 7: reset while ACKing the register byte
        start_cond();
        send_byte(8'hD0, 1'b1, "t7_ack_addr");
        for (int i = 7; i >= 0; i--) begin
            scl_cycle(((8'h33 >> i) & 8'h01) != 8'h00, seen);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            wait_clk(1);
            if (sda_oe === 1'b1) found = 1'b1;
        end
        check("t7_oe_before_rst", 16'(found), 16'd1);
        check("t7_busy_before_rst", 16'(busy), 16'd1);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("t7_oe_after_rst", 16'(sda_oe), 16'd0);
        check("t7_busy_after_rst", 16'(busy), 16'd0);
        sda_m = 1'b1;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(4);
        check("t7_no_ack_slot", 16'(sda_bus), 16'd1);
        wait_clk(4);
        scl_m = 1'b0;
        send_byte(8'h77, 1'b0, "t7_nack_data");
        stop_cond();
        wait_clk(2);
        exp_q.push_back({8'h05, 8'h66});
        start_cond();
        send_byte(8'hD0, 1'b1, "t7_ack_addr2");
        send_byte(8'h05, 1'b1, "t7_ack_reg2");
        send_byte(8'h66, 1'b1, "t7_ack_data2");
        stop_cond();

        wait_clk(20);
        check("final_pending", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
